// File: rtl/uart_boot_loader.sv
// UART program loader: frames A5/len/data/checksum into 32-bit imem writes, holds the core until accepted.
// Latency: one cycle from the final stop-bit sample to imem_we / release / boot_err; no back-pressure.
// BOOT_CHECKSUM_EN enables the trailing checksum byte (CHK state); the default build omits it.
module uart_boot_loader #(
  parameter int CLK_HZ    = 12_000_000,
  parameter int BAUD      = 115_200,
  parameter int MEM_WORDS = 2048,
  localparam int ADDR_W   = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              boot_done,
  output logic              boot_err,
  output logic              frame_err
);

  localparam int CPB   = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]  PTR_ONE  = (ADDR_W + 1)'(1);
  localparam logic [15:0]      MAX_LEN  = 16'(MEM_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef BOOT_CHECKSUM_EN
    CHK,
`endif
    DONE
  } state_t;

  rx_state_t        rx_state;
  logic             rx_s1, rx_s2, rx_prev;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             byte_valid;

  state_t           state;
  logic [7:0]       len_lo;
  logic [ADDR_W:0]  len_q;
  logic [ADDR_W:0]  wr_ptr;
  logic [1:0]       byte_idx;
  logic [23:0]      asm_q;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  logic [15:0]      len_word;
  logic [ADDR_W:0]  wr_ptr_nxt;
  logic             word_last;

  always_comb begin
    len_word   = {rx_shift, len_lo};
    wr_ptr_nxt = wr_ptr + PTR_ONE;
    word_last  = (wr_ptr_nxt == len_q);
  end

  // Start is a high-to-low transition so a line held low after a framing error cannot retrigger.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= uart_rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            bit_cnt  <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (bit_cnt == HALF_END) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (bit_cnt == BIT_END) begin
            bit_cnt  <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (bit_idx == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (bit_cnt == BIT_END) begin
            bit_cnt  <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      len_lo     <= '0;
      len_q      <= '0;
      wr_ptr     <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum       <= '0;
`endif
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      boot_done  <= 1'b0;
      boot_err   <= 1'b0;
    end else begin
      imem_we  <= 1'b0;
      boot_err <= 1'b0;
      // Sitting in IDLE keeps the counters cleared, so any retry reloads from word 0.
      if (state == IDLE) begin
        wr_ptr   <= '0;
        byte_idx <= '0;
`ifdef BOOT_CHECKSUM_EN
        csum     <= '0;
`endif
      end
      if (frame_err) begin
        if (state != DONE) begin
          state <= IDLE;
        end
      end else if (byte_valid) begin
        case (state)
          IDLE: begin
            if (rx_shift == 8'hA5) begin
              state <= LEN_LO;
            end
          end
          LEN_LO: begin
            len_lo <= rx_shift;
            state  <= LEN_HI;
          end
          LEN_HI: begin
            if (len_word > MAX_LEN) begin
              boot_err <= 1'b1;
              state    <= IDLE;
            end else if (len_word == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
              state <= CHK;
`else
              state     <= DONE;
              cpu_hold  <= 1'b0;
              boot_done <= 1'b1;
`endif
            end else begin
              len_q <= len_word[ADDR_W:0];
              state <= DATA;
            end
          end
          DATA: begin
`ifdef BOOT_CHECKSUM_EN
            csum <= csum + rx_shift;
`endif
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= wr_ptr[ADDR_W-1:0];
              imem_wdata <= {rx_shift, asm_q};
              wr_ptr     <= wr_ptr_nxt;
              if (word_last) begin
`ifdef BOOT_CHECKSUM_EN
                state <= CHK;
`else
                state     <= DONE;
                cpu_hold  <= 1'b0;
                boot_done <= 1'b1;
`endif
              end
            end else begin
              // Bytes shift in from the top so the first one ends up in [7:0].
              asm_q <= {rx_shift, asm_q[23:8]};
            end
          end
`ifdef BOOT_CHECKSUM_EN
          CHK: begin
            if (rx_shift == csum) begin
              state     <= DONE;
              cpu_hold  <= 1'b0;
              boot_done <= 1'b1;
            end else begin
              boot_err <= 1'b1;
              state    <= IDLE;
            end
          end
`endif
          DONE: begin
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
